// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction-memory, redirect and consumer signals of fetch_queue
interface fetch_queue_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [INSTR_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0]  inst_pc;

    // fetch_queue side
    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    // memory / core side
    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetch with in-order response FIFO; FETCH_QUEUE_PERF_EN adds perf counters
module fetch_queue #(
    parameter int                    DEPTH       = 4,
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  fq
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]    perf_fetched,
    output logic [31:0]    perf_dropped
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  resp_pc;
    logic [CW-1:0]          count;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          drop_cnt;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [INSTR_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];

    logic [CW:0]   occupancy;
    logic          resp_ok;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] inflight_after_resp;

    // Every outstanding request owns a FIFO slot, so queued plus in-flight never exceeds DEPTH.
    assign occupancy = {1'b0, count} + {1'b0, inflight};
    assign issue     = !reset && !fq.redirect && (occupancy < (CW+1)'(DEPTH));

    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign resp_ok   = fq.imem_rvalid && (inflight != '0);
    assign resp_drop = resp_ok && (drop_cnt != '0);
    assign push      = resp_ok && (drop_cnt == '0) && !fq.redirect;
    assign pop       = fq.inst_valid && fq.inst_ready;

    assign inflight_after_resp = inflight - CW'(resp_ok);

    assign fq.imem_req   = issue;
    assign fq.imem_addr  = fetch_pc;
    assign fq.inst_valid = (count != '0) && !fq.redirect;
    assign fq.inst_data  = data_mem[rd_ptr];
    assign fq.inst_pc    = pc_mem[rd_ptr];

    // Fetch/response PC tracking, outstanding-request accounting and FIFO storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (fq.redirect) begin
            // Everything still outstanding belongs to the old path and must be discarded.
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= fq.redirect_pc;
            resp_pc  <= fq.redirect_pc;
            inflight <= inflight_after_resp;
            drop_cnt <= inflight_after_resp;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            inflight <= inflight + CW'(issue) - CW'(resp_ok);
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                data_mem[wr_ptr] <= fq.imem_rdata;
                pc_mem[wr_ptr]   <= resp_pc;
                wr_ptr           <= wr_ptr + PW'(1);
                resp_pc          <= resp_pc + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic dropped_resp;
    assign dropped_resp = resp_ok && ((drop_cnt != '0) || fq.redirect);

    // Pushed-instruction and discarded-work counters; both wrap freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_dropped <= perf_dropped + 32'(dropped_resp)
                          + (fq.redirect ? 32'(count) : 32'd0);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam int          DEPTH   = 4;
    localparam int          AW      = 64;
    localparam int          IW      = 32;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef struct {
        logic [63:0] addr;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [63:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) fq ();
    fetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) fq2 ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched, perf_dropped, perf_fetched2, perf_dropped2;
`endif

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(64'h0)) dut (
        .clk(clk),
        .reset(reset),
        .fq(fq)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk),
        .reset(reset),
        .fq(fq2)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched(perf_fetched2),
        .perf_dropped(perf_dropped2)
`endif
    );

    int errors = 0;
    int checks = 0;

    // reference model: outstanding requests (in order) and the visible queue
    req_t        mem_q[$];
    ent_t        m_q[$];
    logic [63:0] m_fetch;
    logic [31:0] m_fetched;
    logic [31:0] m_dropped;

    // last sampled outputs of the main DUT
    logic        s_req, s_valid;
    logic [63:0] s_addr, s_pc;

    // second DUT: fixed one-cycle memory, always-ready consumer
    logic        w2_rv_next;
    logic [63:0] w2_addr_next;
    logic [63:0] w2_pcs[$];

    function automatic logic [31:0] fdat(input logic [63:0] a);
        return a[33:2] ^ 32'hC0DE_5A5A;
    endfunction

    task automatic model_clear();
        mem_q.delete();
        m_q.delete();
        m_fetch   = 64'h0;
        m_fetched = 32'h0;
        m_dropped = 32'h0;
        w2_pcs.delete();
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic step(input bit rdy, input bit rv_en, input bit redir,
                        input logic [63:0] rpc, input bit spur);
        bit   exp_req, exp_valid, resp;
        req_t r;
        r = '{64'h0, 1'b0};
        resp = rv_en && (mem_q.size() > 0);
        fq.inst_ready  = rdy;
        fq.redirect    = redir;
        fq.redirect_pc = rpc;
        fq.imem_rvalid = resp || spur;
        fq.imem_rdata  = resp ? fdat(mem_q[0].addr) : $urandom;
        @(negedge clk);
        exp_req   = !redir && ((m_q.size() + mem_q.size()) < DEPTH);
        exp_valid = (m_q.size() != 0) && !redir;
        s_req   = fq.imem_req;
        s_addr  = fq.imem_addr;
        s_valid = fq.inst_valid;
        s_pc    = fq.inst_pc;
        checks++;
        if (fq.imem_req !== exp_req) begin
            errors++;
            $display("FAIL imem_req: got %b expected %b at %0t", fq.imem_req, exp_req, $time);
        end
        if (exp_req) begin
            checks++;
            if (fq.imem_addr !== m_fetch) begin
                errors++;
                $display("FAIL imem_addr: got %h expected %h at %0t", fq.imem_addr, m_fetch, $time);
            end
        end
        checks++;
        if (fq.inst_valid !== exp_valid) begin
            errors++;
            $display("FAIL inst_valid: got %b expected %b at %0t", fq.inst_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (fq.inst_pc !== m_q[0].pc) begin
                errors++;
                $display("FAIL inst_pc: got %h expected %h at %0t", fq.inst_pc, m_q[0].pc, $time);
            end
            checks++;
            if (fq.inst_data !== m_q[0].data) begin
                errors++;
                $display("FAIL inst_data: got %h expected %h at %0t", fq.inst_data, m_q[0].data, $time);
            end
        end
        if (fq2.inst_valid === 1'b1) w2_pcs.push_back(fq2.inst_pc);
        w2_rv_next   = fq2.imem_req;
        w2_addr_next = fq2.imem_addr;

        if (resp) begin
            r = mem_q.pop_front();
            if (r.stale || redir) m_dropped++;
        end
        if (redir) begin
            m_dropped += 32'(m_q.size());
            m_q.delete();
            m_fetch = rpc;
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        end else begin
            if (exp_valid && rdy) void'(m_q.pop_front());
            if (resp && !r.stale) begin
                m_q.push_back('{fq.imem_rdata, r.addr});
                m_fetched++;
            end
            if (exp_req) begin
                mem_q.push_back('{m_fetch, 1'b0});
                m_fetch = m_fetch + 64'd4;
            end
        end
        @(posedge clk);
        #1;
        fq2.imem_rvalid = w2_rv_next;
        fq2.imem_rdata  = fdat(w2_addr_next);
`ifdef FETCH_QUEUE_PERF_EN
        checks++;
        if (perf_fetched !== m_fetched) begin
            errors++;
            $display("FAIL perf_fetched: got %0d expected %0d", perf_fetched, m_fetched);
        end
        checks++;
        if (perf_dropped !== m_dropped) begin
            errors++;
            $display("FAIL perf_dropped: got %0d expected %0d", perf_dropped, m_dropped);
        end
`endif
    endtask

    task automatic idle_inputs();
        fq.imem_rvalid  = 1'b0;
        fq.imem_rdata   = '0;
        fq.redirect     = 1'b0;
        fq.redirect_pc  = '0;
        fq.inst_ready   = 1'b0;
        fq2.imem_rvalid = 1'b0;
        fq2.imem_rdata  = '0;
        fq2.redirect    = 1'b0;
        fq2.redirect_pc = '0;
        fq2.inst_ready  = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (fq.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b expected 0", fq.imem_req); end
        checks++;
        if (fq.imem_addr !== 64'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", fq.imem_addr); end
        checks++;
        if (fq.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", fq.inst_valid); end
        checks++;
        if (fq.inst_data !== 32'h0) begin errors++; $display("FAIL reset_inst_data: got %h expected 0", fq.inst_data); end
        checks++;
        if (fq.inst_pc !== 64'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 0", fq.inst_pc); end
        checks++;
        if (fq2.imem_addr !== WRAP_PC) begin errors++; $display("FAIL reset_wrap_addr: got %h expected %h", fq2.imem_addr, WRAP_PC); end
`ifdef FETCH_QUEUE_PERF_EN
        checks++;
        if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_dropped);
        end
`endif
        do_reset();
    endtask

    task automatic test_stream();
        int          vidx[$];
        logic [63:0] vpc[$];
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
            if (s_valid) begin
                vidx.push_back(i);
                vpc.push_back(s_pc);
            end
        end
        checks++;
        if (vidx.size() < 3) begin
            errors++;
            $display("FAIL stream_count: got %0d valid cycles expected at least 3", vidx.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (vidx[j] != 2 + j || vpc[j] !== 64'(4 * j)) begin
                    errors++;
                    $display("FAIL stream_seq%0d: got cycle %0d pc %h expected cycle %0d pc %h",
                             j, vidx[j], vpc[j], 2 + j, 64'(4 * j));
                end
            end
        end
    endtask

    task automatic test_stall();
        int          nreq = 0;
        int          nreq_after = 0;
        logic [63:0] pcs[$];
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
            if (s_req) nreq++;
        end
        checks++;
        if (nreq != DEPTH) begin errors++; $display("FAIL stall_requests: got %0d expected %0d", nreq, DEPTH); end
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: got req=%b valid=%b expected req=0 valid=1", s_req, s_valid);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
            if (s_valid) pcs.push_back(s_pc);
            if (s_req) nreq_after++;
        end
        checks++;
        if (pcs.size() != DEPTH) begin
            errors++;
            $display("FAIL stall_release: got %0d pops expected %0d", pcs.size(), DEPTH);
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                checks++;
                if (pcs[j] !== 64'(4 * j)) begin
                    errors++;
                    $display("FAIL stall_order%0d: got %h expected %h", j, pcs[j], 64'(4 * j));
                end
            end
        end
        checks++;
        if (nreq_after == 0) begin errors++; $display("FAIL stall_resume: got 0 requests expected some"); end
    endtask

    task automatic test_redirect();
        int          first = -1;
        logic [63:0] first_pc = 64'h0;
        logic [31:0] drop_base;
        int          budget;
        do_reset();
        budget = 0;
        while (m_q.size() < 2 && budget < 20) begin
            step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
            budget++;
        end
        while (mem_q.size() < 2 && budget < 40) begin
            step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
            budget++;
        end
        checks++;
        if (budget >= 40) begin errors++; $display("FAIL redirect_setup: got timeout expected 2 queued 2 in flight"); end
        drop_base = m_dropped;
        step(1'b1, 1'b0, 1'b1, 64'h1000, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
            if (s_valid && first < 0) begin
                first    = j;
                first_pc = s_pc;
            end
        end
        checks++;
        if (first != 3 || first_pc !== 64'h1000) begin
            errors++;
            $display("FAIL redirect_first: got cycle %0d pc %h expected cycle 3 pc 1000", first, first_pc);
        end
`ifdef FETCH_QUEUE_PERF_EN
        checks++;
        if (perf_dropped - drop_base !== 32'd4) begin
            errors++;
            $display("FAIL redirect_perf_dropped: got +%0d expected +4", perf_dropped - drop_base);
        end
`else
        drop_base = drop_base + 32'd0;
`endif
    endtask

    task automatic test_spurious();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_pc !== 64'h0 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious: got valid=%b pc=%h req=%b expected 1/0/0", s_valid, s_pc, s_req);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [63:0] exp_pcs[4];
        exp_pcs[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_pcs[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_pcs[2] = 64'h0;
        exp_pcs[3] = 64'h4;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        checks++;
        if (w2_pcs.size() < 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected at least 4", w2_pcs.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (w2_pcs[j] !== exp_pcs[j]) begin
                    errors++;
                    $display("FAIL wrap_pc%0d: got %h expected %h", j, w2_pcs[j], exp_pcs[j]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (fq.inst_valid !== 1'b0 || fq.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL midreset_immediate: got valid=%b req=%b expected 0/0", fq.inst_valid, fq.imem_req);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 64'h0) begin
            errors++;
            $display("FAIL midreset_restart: got req=%b addr=%h expected 1/0", s_req, s_addr);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] hi, lo;
        bit          rdy, rv, redir, spur;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            hi    = $urandom;
            lo    = $urandom;
            lo[1:0] = 2'b00;
            rdy   = ($urandom % 4) != 0;
            rv    = ($urandom % 3) != 0;
            redir = ($urandom % 25) == 0;
            spur  = (mem_q.size() == 0) && (($urandom % 10) == 0);
            step(rdy, rv, redir, {hi, lo}, spur);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_clear();
        s_req = 1'b0; s_valid = 1'b0; s_addr = '0; s_pc = '0;
        w2_rv_next = 1'b0; w2_addr_next = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_spurious();
        test_wrap();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
